// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx : parallel-in, serial-out word transmitter
//
// Accepts a WIDTH-bit word over a valid/ready handshake. It shifts the word out
// one bit per clock, LSB first. Each bit comes with a valid strobe, and the
// final bit of the frame also carries a last marker. GAP idle cycles can be
// forced between frames. When GAP is 0, a new word can be taken in the final
// bit cycle, so frames run back-to-back.
//
// Every output is driven straight from a flop. Each output flop is loaded from
// the decode of the next state. As a result, the outputs always describe the
// state the block is in, and no combinational path runs from I_VALID to any
// output.
//
// Ports
//   CLK       in   system clock, rising edge
//   RESETN    in   asynchronous active-low reset
//   I         in   [WIDTH-1:0] parallel word to transmit
//   I_VALID   in   I holds a word to send
//   I_READY   out  block can accept a word this cycle
//   SO        out  serial data bit
//   SO_VALID  out  SO carries a valid bit this cycle
//   SO_LAST   out  SO is bit WIDTH-1 of the current frame
//   BUSY      out  a frame (shift or inter-frame gap) is in progress
// -----------------------------------------------------------------------------
module piso_tx #(
  parameter int WIDTH = 5,
  parameter int GAP   = 0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic             SO,
  output logic             SO_VALID,
  output logic             SO_LAST,
  output logic             BUSY
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  // GAP_LAST is only consulted when GAP > 0. The guard keeps the constant
  // legal when GAP is 0.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] shreg_q,    shreg_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [GAP_W-1:0] gap_q,      gap_d;
  logic             so_q,       so_d;
  logic             so_valid_q, so_valid_d;
  logic             so_last_q,  so_last_d;
  logic             busy_q,     busy_d;
  logic             i_ready_q,  i_ready_d;

  logic             accept;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;

    // The handshake uses the registered ready. I_VALID only steers flop inputs.
    accept = I_VALID && i_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = I;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
            shreg_d = '0;
            cnt_d   = '0;
          end else if (accept) begin
            // Back-to-back frame: the next word loads while the last bit
            // of the current frame is on the wire.
            shreg_d = I;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
          end
        end else begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  // Output decode of the next state, registered alongside it
  always_comb begin
    so_valid_d = (state_d == ST_SHIFT);
    so_d       = so_valid_d && shreg_d[0];
    so_last_d  = so_valid_d && (cnt_d == CNT_LAST);
    busy_d     = (state_d != ST_IDLE);
    // Ready is asserted in IDLE, and also in the final bit cycle when no gap
    // is enforced.
    i_ready_d  = (state_d == ST_IDLE) || (so_last_d && (GAP == 0));
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      i_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      so_last_q  <= so_last_d;
      busy_q     <= busy_d;
      i_ready_q  <= i_ready_d;
    end
  end

  assign I_READY  = i_ready_q;
  assign SO       = so_q;
  assign SO_VALID = so_valid_q;
  assign SO_LAST  = so_last_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx : bench for piso_tx
//
// Two instances share one stimulus stream. u_g0 has GAP=0 and u_g3 has GAP=3.
// A timeline model tracks each instance. For every instance it records the
// cycle at which the current frame's first bit appears, together with the word
// captured at the handshake. Each cycle's expected outputs are then derived
// from the offset between the current cycle and that start.
// -----------------------------------------------------------------------------
module tb_piso_tx;

  localparam int W = 5;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic [W-1:0] i_data;
  logic [1:0]   i_ready, so, so_valid, so_last, busy;

  int           n_pass  = 0;
  int           n_total = 0;

  // Model state: cycles since reset release and per-instance frame timeline
  int           cyc       = 0;
  int           fstart[2] = '{-1000, -1000};
  logic [W-1:0] fword[2]  = '{'0, '0};

  piso_tx #(.WIDTH(W), .GAP(0)) u_g0 (
    .CLK(clk), .RESETN(rst_n), .I(i_data), .I_VALID(i_valid),
    .I_READY(i_ready[0]), .SO(so[0]), .SO_VALID(so_valid[0]),
    .SO_LAST(so_last[0]), .BUSY(busy[0])
  );

  piso_tx #(.WIDTH(W), .GAP(3)) u_g3 (
    .CLK(clk), .RESETN(rst_n), .I(i_data), .I_VALID(i_valid),
    .I_READY(i_ready[1]), .SO(so[1]), .SO_VALID(so_valid[1]),
    .SO_LAST(so_last[1]), .BUSY(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Expected {rdy, busy, last, vld, so} for instance k in cycle c
  function automatic logic [4:0] exp_at(input int k, input int c);
    int           off;
    logic [W-1:0] sh;
    logic         e_so, e_vld, e_last, e_busy, e_rdy;
    e_so = 0; e_vld = 0; e_last = 0; e_busy = 0; e_rdy = 0;
    if (rst_n) begin
      off = c - fstart[k];
      if (off >= 0 && off < W) begin
        sh     = fword[k] >> off;
        e_so   = sh[0];
        e_vld  = 1;
        e_last = (off == W - 1);
        e_busy = 1;
        e_rdy  = (off == W - 1) && (gap_of(k) == 0);
      end else if (off >= W && off < W + gap_of(k)) begin
        e_busy = 1;
      end else begin
        e_rdy = (c > 0);
      end
    end
    return {e_rdy, e_busy, e_last, e_vld, e_so};
  endfunction

  function automatic logic model_ready(input int k, input int c);
    logic [4:0] e;
    e = exp_at(k, c);
    return e[4];
  endfunction

  // Model update: a handshake at this edge starts a frame on the next cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int k = 0; k < 2; k++) fstart[k] <= -1000;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (i_valid && model_ready(k, cyc)) begin
          fstart[k] <= cyc + 1;
          fword[k]  <= i_data;
        end
      end
      cyc <= cyc + 1;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin : compare
    logic [4:0] e;
    for (int k = 0; k < 2; k++) begin
      e = exp_at(k, cyc);
      chk($sformatf("cyc%0d dut%0d {rdy,busy,last,vld,so}", cyc, k),
          {27'd0, i_ready[k], busy[k], so_last[k], so_valid[k], so[k]},
          {27'd0, e});
    end
  end

  initial begin : stim
    logic [4:0] cap, lst;
    logic [9:0] cap10, lst10, vld10;
    int         gapc, rdy_in_gap, first_idx;
    bit         seen_last;

    rst_n = 1'b0; i_valid = 1'b0; i_data = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("ready_in_reset", i_ready, 2'b00);
    chk("busy_vld_in_reset", {busy, so_valid}, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", i_ready, 2'b11);

    // Single frame 5'b10110
    i_valid = 1'b1; i_data = 5'b10110;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      cap[j] = so[0];
      lst[j] = so_last[0];
    end
    chk("single_bits", cap, 5'b10110);
    chk("single_last", lst, 5'b10000);
    @(negedge clk);
    chk("single_idle_ready", i_ready[0], 1'b1);
    chk("single_idle_vld", so_valid[0], 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back: 1F, then 00 presented in the last-bit cycle
    i_valid = 1'b1; i_data = 5'h1F;
    @(posedge clk); #1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      cap10[j] = so[0];
      lst10[j] = so_last[0];
      vld10[j] = so_valid[0];
      @(posedge clk); #1;
      if (j == 3) i_data = 5'h00;
      if (j == 4) i_valid = 1'b0;
    end
    chk("b2b_bits", cap10, 10'b0000011111);
    chk("b2b_last", lst10, 10'b1000010000);
    chk("b2b_valid", vld10, 10'h3FF);
    repeat (5) @(posedge clk);
    #1;

    // Gap enforcement on the GAP=3 instance; I changes every cycle
    i_valid = 1'b1; i_data = W'($urandom);
    gapc = 0; rdy_in_gap = 0; first_idx = -1; seen_last = 0;
    for (int t = 0; t < 40 && first_idx < 0; t++) begin
      @(negedge clk);
      if (seen_last) begin
        if (so_valid[1]) first_idx = t;
        else begin
          gapc++;
          if (i_ready[1]) rdy_in_gap++;
        end
      end else if (so_last[1]) begin
        seen_last = 1;
      end
      @(posedge clk); #1;
      i_data = W'($urandom);
    end
    i_valid = 1'b0;
    chk("gap_next_frame_seen", first_idx >= 0, 1);
    chk("gap_idle_cycles", gapc, 4);
    chk("gap_ready_cycles", rdy_in_gap, 1);
    repeat (10) @(posedge clk);
    #1;

    // Mid-frame reset after bit 2
    i_valid = 1'b1; i_data = 5'b11111;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_vld", so_valid, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {so, so_valid, so_last, busy, i_ready}, 10'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = 5'b01101;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      cap[j] = so[0];
    end
    chk("post_reset_bits", cap, 5'b01101);
    repeat (8) @(posedge clk);
    #1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = W'($urandom);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
